// File: rtl/led_pulse_stretch.sv
// Per-channel LED pulse stretcher. N channels share one free-running hold-tick prescaler.
// Optional macro STRETCH_EDGE_EN: a channel triggers only on a rising edge of pulse, not on every high cycle.
module led_pulse_stretch #(
   parameter int unsigned N          = 4,
   parameter int unsigned PRESCALE   = 50000,
   parameter int unsigned HOLD_TICKS = 3
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [N-1:0] pulse,
   output logic [N-1:0] led,
   output logic         busy
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned CW = $clog2(HOLD_TICKS + 1);
   localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_TICKS);

   generate
      if (N < 1 || N > 32 || PRESCALE < 1 || HOLD_TICKS < 1) begin : g_bad_param
         $error("led_pulse_stretch: illegal parameter value");
      end
   endgenerate

   logic [PW-1:0] pre;
   logic          tick;
   logic [N-1:0]  trigger;
   logic [CW-1:0] cnt     [N];
   logic [CW-1:0] cnt_nxt [N];
   logic [N-1:0]  led_nxt;

   always_comb tick = (pre == PRE_MAX);

`ifdef STRETCH_EDGE_EN
   logic [N-1:0] pulse_q;

   always_ff @(posedge Clk) begin
      if (Reset) pulse_q <= '0;
      else       pulse_q <= pulse;
   end

   assign trigger = pulse & ~pulse_q;
`else
   assign trigger = pulse;
`endif

   // A trigger reload takes priority over a same-cycle tick decrement.
   always_comb begin
      led_nxt = '0;
      for (int i = 0; i < int'(N); i++) begin
         cnt_nxt[i] = cnt[i];
         if (trigger[i])
            cnt_nxt[i] = CNT_LOAD;
         else if (tick && cnt[i] != '0)
            cnt_nxt[i] = cnt[i] - CW'(1);
         led_nxt[i] = (cnt_nxt[i] != '0);
      end
   end

   // led/busy are registered alongside cnt so they always equal (cnt != 0).
   always_ff @(posedge Clk) begin
      if (Reset) begin
         pre  <= '0;
         led  <= '0;
         busy <= 1'b0;
         for (int i = 0; i < int'(N); i++) cnt[i] <= '0;
      end else begin
         pre  <= tick ? '0 : pre + PW'(1);
         led  <= led_nxt;
         busy <= |led_nxt;
         for (int i = 0; i < int'(N); i++) cnt[i] <= cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Self-checking bench for led_pulse_stretch (N=4, PRESCALE=4, HOLD_TICKS=3).
// Expected led/busy per cycle come from the on-time windows, queued as stimulus is driven.
module tb_led_pulse_stretch;

   localparam int unsigned N = 4;

   typedef struct packed {
      logic [N-1:0] led;
      logic         busy;
   } exp_t;

   logic         Clk = 1'b0;
   logic         Reset;
   logic [N-1:0] pulse;
   logic [N-1:0] led;
   logic         busy;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   led_pulse_stretch #(.N(N), .PRESCALE(4), .HOLD_TICKS(3)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .pulse (pulse),
      .led   (led),
      .busy  (busy)
   );

   always #5 Clk = ~Clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bit win(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   function automatic exp_t mk(input logic [N-1:0] l);
      exp_t e;
      e.led  = l;
      e.busy = |l;
      return e;
   endfunction

   // Leaves the bench mid-cycle c0: Reset already low, pre=0 in this cycle.
   task automatic do_reset();
      Reset = 1'b1;
      pulse = '0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      Reset = 1'b1;
      pulse = '1;
      for (int c = 0; c < 4; c++) begin
         q.push_back(mk('0));
         @(negedge Clk);
         if (c > 0) begin
            e = q.pop_front();
            checks++;
            if ({led, busy} !== {e.led, e.busy}) begin
               errors++;
               $display("FAIL reset c%0d: led=%b busy=%b expected led=%b busy=%b", c, led, busy, e.led, e.busy);
            end
         end
      end
      q.delete();
      pulse = '0;
   endtask

   task automatic test_single();
      exp_t e;
      do_reset();
      q.push_back(mk('0));
      for (int c = 0; c <= 14; c++) begin
         e = q.pop_front();
         checks++;
         if ({led, busy} !== {e.led, e.busy}) begin
            errors++;
            $display("FAIL single c%0d: led=%b busy=%b expected led=%b busy=%b", c, led, busy, e.led, e.busy);
         end
         pulse = (c == 0) ? 4'b0001 : 4'b0000;
         q.push_back(mk(win(c + 1, 1, 11) ? 4'b0001 : 4'b0000));
         @(negedge Clk);
      end
      q.delete();
   endtask

   task automatic test_tick_phase();
      exp_t e;
      int   at, lo, hi;
      for (int v = 0; v < 2; v++) begin
         at = (v == 0) ? 3 : 2;
         lo = at + 1;
         hi = (v == 0) ? 15 : 11;
         do_reset();
         q.push_back(mk('0));
         for (int c = 0; c <= 18; c++) begin
            e = q.pop_front();
            checks++;
            if ({led, busy} !== {e.led, e.busy}) begin
               errors++;
               $display("FAIL tick_phase at=c%0d c%0d: led=%b busy=%b expected led=%b busy=%b", at, c, led, busy, e.led, e.busy);
            end
            pulse = (c == at) ? 4'b0001 : 4'b0000;
            q.push_back(mk(win(c + 1, lo, hi) ? 4'b0001 : 4'b0000));
            @(negedge Clk);
         end
         q.delete();
      end
   endtask

   // Reload at c9, then ticks at c11/c15/c19 bring the count to zero.
   task automatic test_retrigger();
      exp_t e;
      do_reset();
      q.push_back(mk('0));
      for (int c = 0; c <= 24; c++) begin
         e = q.pop_front();
         checks++;
         if ({led, busy} !== {e.led, e.busy}) begin
            errors++;
            $display("FAIL retrigger c%0d: led=%b busy=%b expected led=%b busy=%b", c, led, busy, e.led, e.busy);
         end
         pulse = (c == 0 || c == 9) ? 4'b0010 : 4'b0000;
         q.push_back(mk(win(c + 1, 1, 19) ? 4'b0010 : 4'b0000));
         @(negedge Clk);
      end
      q.delete();
   endtask

   task automatic test_multi_channel();
      exp_t         e;
      logic [N-1:0] l;
      do_reset();
      q.push_back(mk('0));
      for (int c = 0; c <= 18; c++) begin
         e = q.pop_front();
         checks++;
         if ({led, busy} !== {e.led, e.busy}) begin
            errors++;
            $display("FAIL multi c%0d: led=%b busy=%b expected led=%b busy=%b", c, led, busy, e.led, e.busy);
         end
         pulse = (c == 0) ? 4'b1111 : (c == 5) ? 4'b0100 : 4'b0000;
         l = win(c + 1, 1, 11) ? 4'b1011 : 4'b0000;
         l[2] = win(c + 1, 1, 15);
         q.push_back(mk(l));
         @(negedge Clk);
      end
      q.delete();
   endtask

   // Reset in c6 (with a pulse); c7 restarts as a fresh c0, then a pulse at new c2.
   task automatic test_reset_mid();
      exp_t e;
      int   n;
      do_reset();
      q.push_back(mk('0));
      for (int c = 0; c <= 21; c++) begin
         e = q.pop_front();
         checks++;
         if ({led, busy} !== {e.led, e.busy}) begin
            errors++;
            $display("FAIL reset_mid c%0d: led=%b busy=%b expected led=%b busy=%b", c, led, busy, e.led, e.busy);
         end
         Reset = (c == 6);
         pulse = (c == 0 || c == 6 || c == 9) ? 4'b0001 : 4'b0000;
         n = c + 1;
         if (n <= 6) q.push_back(mk(win(n, 1, 6) ? 4'b0001 : 4'b0000));
         else        q.push_back(mk(win(n - 7, 3, 11) ? 4'b0001 : 4'b0000));
         @(negedge Clk);
      end
      q.delete();
      Reset = 1'b0;
   endtask

   task automatic test_level_hold();
      exp_t e;
      int   hi;
`ifdef STRETCH_EDGE_EN
      hi = 11;
`else
      hi = 31;
`endif
      do_reset();
      q.push_back(mk('0));
      for (int c = 0; c <= 35; c++) begin
         e = q.pop_front();
         checks++;
         if ({led, busy} !== {e.led, e.busy}) begin
            errors++;
            $display("FAIL level_hold c%0d: led=%b busy=%b expected led=%b busy=%b", c, led, busy, e.led, e.busy);
         end
         pulse = (c <= 19) ? 4'b1000 : 4'b0000;
         q.push_back(mk(win(c + 1, 1, hi) ? 4'b1000 : 4'b0000));
         @(negedge Clk);
      end
      q.delete();
   endtask

   initial begin
      Reset = 1'b1;
      pulse = '0;
      @(negedge Clk);
      test_reset();
      test_single();
      test_tick_phase();
      test_retrigger();
      test_multi_channel();
      test_reset_mid();
      test_level_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
